mmio_uart: RTL and testbench

- Memory-mapped UART device on the CPU data port (port B), occupying the UART IN READY / UART OUT READY / UART IN-OUT words of the device window.
- Contains a serial receiver feeding an RX FIFO, and a serial transmitter driven by CPU writes.
- It is a bus responder: it decodes addr_b, returns read data with strobe_b into the top-level read mux, and consumes writes gated by data_b_we.
- Fixed frame format 8N1, LSB first, idle-high line.

---
 rtl/soc_uart_pkg.sv | 18 +
 rtl/mmio_uart_rx_fifo.sv | 72 +++++++
 rtl/mmio_uart.sv | 225 ++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, frame width
// and the state encoding used by both the transmit and receive FSMs.
package soc_uart_pkg;

    localparam int unsigned OFF_RXRDY = 0;
    localparam int unsigned OFF_TXRDY = 1;
    localparam int unsigned OFF_DATA  = 2;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_rx_fifo.sv
// Synchronous receive FIFO for the UART; push-when-full and pop-when-empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_fifo
    import soc_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] head,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned    AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART responder on data port B: RX-ready, TX-ready and data words.
// Define UART_RX_ERR_EN to add sticky overflow/framing flags at RX-ready bits [1] and [2].
module mmio_uart
    import soc_uart_pkg::*;
#(
    parameter int unsigned BASE     = 65537,
    parameter int unsigned CLK_DIV  = 434,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic        data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam logic [31:0] ADDR_RXRDY = 32'(BASE + OFF_RXRDY);
    localparam logic [31:0] ADDR_TXRDY = 32'(BASE + OFF_TXRDY);
    localparam logic [31:0] ADDR_DATA  = 32'(BASE + OFF_DATA);

    localparam int unsigned      CNT_W     = $clog2(CLK_DIV);
    localparam int unsigned      BIT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic sel_rxrdy, sel_txrdy, sel_data;
    logic wr_rxrdy, wr_data;

    assign sel_rxrdy = (addr_b == ADDR_RXRDY);
    assign sel_txrdy = (addr_b == ADDR_TXRDY);
    assign sel_data  = (addr_b == ADDR_DATA);
    assign strobe_b  = sel_rxrdy | sel_txrdy | sel_data;
    assign wr_rxrdy  = data_b_we && sel_rxrdy;
    assign wr_data   = data_b_we && sel_data;

    // ---------------- transmitter ----------------
    uart_state_t          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready, tx_launch, tx_tick;

    assign tx_launch = wr_data && tx_ready;
    assign tx_tick   = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            IDLE:    if (tx_launch) tx_state_d = START;
            START:   if (tx_tick) tx_state_d = DATA;
            DATA:    if (tx_tick && tx_bit_q == LAST_BIT) tx_state_d = STOP;
            STOP:    if (tx_tick) tx_state_d = IDLE;
            default: tx_state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_cnt_d   = (tx_state_q == IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_launch) begin
            tx_shift_d = data_b_in[DATA_BITS-1:0];
            tx_bit_d   = '0;
        end else if (tx_state_q == DATA && tx_tick) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 1'b1;
        end
    end

    // Line level is decided from the next state so uart_tx stays a plain flop.
    always_comb begin
        tx_ready = (tx_state_q == IDLE);
        case (tx_state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx = tx_q;

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_t          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_fall, rx_sample, rx_push, rx_frame_err;

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Start bit is sampled at its middle; every later sample is one bit period on.
    always_comb begin
        case (rx_state_q)
            START:      rx_sample = (rx_cnt_q == HALF_LAST);
            DATA, STOP: rx_sample = (rx_cnt_q == BIT_LAST);
            default:    rx_sample = 1'b0;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            IDLE:    if (rx_fall) rx_state_d = START;
            START:   if (rx_sample) rx_state_d = rx_sync_q ? IDLE : DATA;
            DATA:    if (rx_sample && rx_bit_q == LAST_BIT) rx_state_d = STOP;
            STOP:    if (rx_sample) rx_state_d = IDLE;
            default: rx_state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d   = (rx_state_q == IDLE || rx_sample) ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d   = (rx_state_q == DATA) ? rx_bit_q : '0;
        rx_shift_d = rx_shift_q;
        if (rx_state_q == DATA && rx_sample) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
        end
    end

    always_comb begin
        rx_push      = (rx_state_q == STOP) && rx_sample && rx_sync_q;
        rx_frame_err = (rx_state_q == STOP) && rx_sample && !rx_sync_q;
    end

    // ---------------- FIFO, flags, read mux ----------------
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_empty, fifo_full;
    logic [1:0]           err_flags;
    logic                 unused_bits;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (wr_rxrdy),
        .din   (rx_shift_q),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef UART_RX_ERR_EN
    logic ovf_q, ovf_d, frm_q, frm_d;

    // A new error in the same cycle as a clearing write wins.
    always_comb begin
        ovf_d = (rx_push && fifo_full) || (ovf_q && !wr_rxrdy);
        frm_d = rx_frame_err || (frm_q && !wr_rxrdy);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            frm_q <= frm_d;
        end
    end

    assign err_flags   = {frm_q, ovf_q};
    assign unused_bits = ^data_b_in[31:DATA_BITS];
`else
    assign err_flags   = 2'b00;
    assign unused_bits = ^{data_b_in[31:DATA_BITS], fifo_full, rx_frame_err};
`endif

    always_comb begin
        data_b = '0;
        if (sel_rxrdy) begin
            data_b = {29'b0, err_flags, ~fifo_empty};
        end else if (sel_txrdy) begin
            data_b = {31'b0, tx_ready};
        end else if (sel_data) begin
            data_b = {24'b0, fifo_head};
        end
    end

endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboard bench for mmio_uart: a spec-level model predicts bus reads and serial TX frames;
// independent monitors compare them against the DUT.
`timescale 1ns/1ps
module tb_mmio_uart;

    localparam int unsigned BASE     = 65537;
    localparam int unsigned CLK_DIV  = 8;
    localparam int unsigned RX_DEPTH = 4;
    localparam logic [31:0] A_RXRDY  = 32'(BASE);
    localparam logic [31:0] A_TXRDY  = 32'(BASE + 1);
    localparam logic [31:0] A_DATA   = 32'(BASE + 2);
    localparam int unsigned FRAME    = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic        data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;
    logic        uart_rx;
    logic        uart_tx;

    mmio_uart #(
        .BASE     (BASE),
        .CLK_DIV  (CLK_DIV),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_b    (addr_b),
        .data_b_in (data_b_in),
        .data_b_we (data_b_we),
        .data_b    (data_b),
        .strobe_b  (strobe_b),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  rx_m[$];
    logic        ovf_m = 1'b0;
    logic        frm_m = 1'b0;
    int unsigned tx_free = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned launch;
    } tx_exp_t;
    tx_exp_t tx_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        strobe;
    } rd_exp_t;
    rd_exp_t rd_q[$];
    logic    rd_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycle(input int unsigned target);
        int unsigned budget = 1000;
        while (cyc < target && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check("wait_cycle_timeout", cyc, target);
    endtask

    // Expected read value at the current (pre-edge) state.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a == A_RXRDY) begin
            r[0] = (rx_m.size() != 0);
`ifdef UART_RX_ERR_EN
            r[1] = ovf_m;
            r[2] = frm_m;
`endif
        end else if (a == A_TXRDY) begin
            r[0] = (cyc >= tx_free);
        end else if (a == A_DATA && rx_m.size() != 0) begin
            r[7:0] = rx_m[0];
        end
        return r;
    endfunction

    task automatic expect_read(input logic [31:0] a);
        rd_exp_t e;
        e.addr   = a;
        e.data   = model_read(a);
        e.strobe = (a >= A_RXRDY) && (a <= A_DATA);
        rd_q.push_back(e);
    endtask

    task automatic bus_read(input logic [31:0] a);
        expect_read(a);
        addr_b   = a;
        rd_valid = 1'b1;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
    endtask

    // Each write also checks that the same-cycle read shows pre-edge state.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        tx_exp_t t;
        expect_read(a);
        if (a == A_RXRDY) begin
            if (rx_m.size() != 0) void'(rx_m.pop_front());
            ovf_m = 1'b0;
            frm_m = 1'b0;
        end else if (a == A_DATA && cyc >= tx_free) begin
            t.data   = d[7:0];
            t.launch = cyc + 1;
            tx_q.push_back(t);
            tx_free = cyc + 1 + FRAME;
        end
        addr_b    = a;
        data_b_in = d;
        data_b_we = 1'b1;
        rd_valid  = 1'b1;
        @(posedge clk);
        #1;
        data_b_we = 1'b0;
        rd_valid  = 1'b0;
        data_b_in = $urandom;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            tick(CLK_DIV);
        end
        uart_rx = 1'b1;
        tick(4);
        if (!stop_bit) frm_m = 1'b1;
        else if (rx_m.size() < RX_DEPTH) rx_m.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        tick(n);
        rst = 1'b1;
        rx_m.delete();
        ovf_m   = 1'b0;
        frm_m   = 1'b0;
        tx_free = 0;
        tx_q.delete();
    endtask

    // Read monitor
    initial begin : rd_monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                check("read_scoreboard_nonempty", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check($sformatf("data_b@%0d", e.addr), data_b, e.data);
                    check($sformatf("strobe_b@%0d", e.addr), 32'(strobe_b), 32'(e.strobe));
                end
            end
        end
    end

    // Serial TX monitor: every cycle of every bit is compared against the expected frame.
    initial begin : tx_monitor
        tx_exp_t    e;
        logic [9:0] frame;
        logic       ok, aborted, have;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_tx === 1'b0) begin
                have = (tx_q.size() != 0);
                check("tx_frame_expected", 32'(have), 32'd1);
                frame = 10'h3ff;
                if (have) begin
                    e = tx_q.pop_front();
                    check("tx_start_cycle", cyc, e.launch);
                    frame = {1'b1, e.data, 1'b0};
                end
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    ok = 1'b1;
                    for (int k = 0; k < CLK_DIV && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst !== 1'b1) aborted = 1'b1;
                        else if (uart_tx !== frame[b]) ok = 1'b0;
                    end
                    if (!aborted && have) check($sformatf("tx_bit%0d", b), 32'(ok), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin : stimulus
        int unsigned t;
        rst       = 1'b0;
        addr_b    = '0;
        data_b_in = '0;
        data_b_we = 1'b0;
        uart_rx   = 1'b1;
        tick(1);
        apply_reset(3);

        // Post-reset state
        check("tx_idle_after_reset", 32'(uart_tx), 32'd1);
        bus_read(A_RXRDY);
        bus_read(A_TXRDY);
        bus_read(32'd65540);
        bus_read(A_DATA);
        bus_read(32'(BASE - 1));

        // TX frame of 0x1A5 (low byte 0xA5) with a dropped write mid-frame
        t = cyc + 1;
        bus_write(A_DATA, 32'h1A5);
        bus_read(A_TXRDY);
        tick(20);
        bus_write(A_DATA, 32'h0000_0055);
        wait_cycle(t + FRAME - 1);
        bus_read(A_TXRDY);
        bus_read(A_TXRDY);

        // RX byte 0x3C
        send_rx(8'h3C, 1'b1);
        bus_read(A_RXRDY);
        bus_read(A_DATA);
        bus_write(A_RXRDY, 32'h0);
        bus_read(A_RXRDY);

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        bus_read(A_RXRDY);
        bus_read(A_DATA);
        bus_write(A_RXRDY, $urandom);
        bus_read(A_RXRDY);
        repeat (4) begin
            bus_read(A_DATA);
            bus_write(A_RXRDY, $urandom);
        end
        bus_read(A_RXRDY);

        // Framing error, then a short glitch, then a clean byte
        send_rx(8'hA5, 1'b0);
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(2 * CLK_DIV);
        bus_read(A_RXRDY);
        bus_read(A_DATA);
        send_rx(8'h7E, 1'b1);
        bus_read(A_RXRDY);
        bus_read(A_DATA);
        bus_write(A_RXRDY, 32'h0);

        // Randomized mix
        repeat (40) begin
            case ($urandom_range(0, 4))
                0: bus_write(A_DATA, $urandom);
                1: send_rx(8'($urandom), $urandom_range(0, 7) != 0);
                2: bus_write(A_RXRDY, $urandom);
                3: bus_read(32'(BASE - 1 + $urandom_range(0, 4)));
                default: begin
                    tick($urandom_range(1, 30));
                    bus_write($urandom_range(0, 1) != 0 ? A_TXRDY : 32'(BASE + 3), $urandom);
                end
            endcase
        end

        // Reset mid TX frame with two bytes queued
        while (rx_m.size() != 0) bus_write(A_RXRDY, 32'h0);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        wait_cycle(tx_free);
        bus_write(A_DATA, 32'h0000_00C3);
        tick(25);
        apply_reset(1);
        check("tx_high_after_mid_frame_reset", 32'(uart_tx), 32'd1);
        bus_read(A_RXRDY);
        bus_read(A_TXRDY);
        bus_read(A_DATA);

        // One more frame after reset, then drain
        bus_write(A_DATA, 32'h0000_005A);
        wait_cycle(tx_free + 2);
        check("tx_queue_drained", tx_q.size(), 32'd0);
        check("read_queue_drained", rd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
